// File: rtl/snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : snoop_responder
// Description : Coherence snoop responder for a 2-way, 8-set, 2-word-block
//               dcache. Accepts a snoop from the memory controller, looks the
//               address up through the dcache arrays, supplies a dirty block
//               word by word, downgrades or invalidates the line, and clears
//               a matching LL reservation on invalidating snoops.
// Ports       : CLK, nRST             - clock, async active-low reset
//               ccwait/ccinv/ccsnoopaddr - snoop request from controller
//               lk_addr / lk_*        - array lookup address and result
//               dwait                 - controller word-accept stall
//               cctrans/ccwrite/snp_dstore - snoop response to controller
//               upd_en/upd_way/upd_inv - one-cycle array state update
//               link_addr/link_valid/link_clr - LL reservation interface
//               snoop_busy            - arrays owned by the snooper
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_responder (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic [31:0] lk_addr,
  input  logic        lk_hit,
  input  logic        lk_dirty,
  input  logic        lk_way,
  input  logic [31:0] lk_data0,
  input  logic [31:0] lk_data1,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  output logic [31:0] snp_dstore,
  output logic        upd_en,
  output logic        upd_way,
  output logic        upd_inv,
  input  logic [31:0] link_addr,
  input  logic        link_valid,
  output logic        link_clr,
  output logic        snoop_busy
);

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_LOOKUP = 3'd1;
  localparam logic [2:0] C_SUP1   = 3'd2;
  localparam logic [2:0] C_SUP2   = 3'd3;
  localparam logic [2:0] C_UPDATE = 3'd4;
  localparam logic [2:0] C_DONE   = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [31:0] r_addr;
  logic        r_inv;
  logic        r_hit;
  logic        r_dirty;
  logic        r_way;
  logic [31:0] r_data0;
  logic [31:0] r_data1;
  logic        w_link_match;
  logic        w_unused;

  // Byte/word offset inside the reservation is irrelevant to block matching.
  assign w_unused = &{1'b0, link_addr[2:0]};

  // Reservation granularity is the 8-byte block.
  assign w_link_match = link_valid && (link_addr[31:3] == r_addr[31:3]);

  // lk_addr comes straight from the latched address, so it only ever changes
  // on entry to LOOKUP and otherwise holds the last snooped address.
  assign lk_addr = r_addr;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Snoop context and lookup capture
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr  <= 32'd0;
      r_inv   <= 1'b0;
      r_hit   <= 1'b0;
      r_dirty <= 1'b0;
      r_way   <= 1'b0;
      r_data0 <= 32'd0;
      r_data1 <= 32'd0;
    end else begin
      if (r_state == C_IDLE && ccwait) begin
        r_addr <= ccsnoopaddr;
        r_inv  <= ccinv;
      end
      // Lookup results are only trusted during LOOKUP; later changes on the
      // lk_* inputs have no effect on the rest of the snoop.
      if (r_state == C_LOOKUP) begin
        r_hit   <= lk_hit;
        r_dirty <= lk_dirty;
        r_way   <= lk_way;
        r_data0 <= lk_data0;
        r_data1 <= lk_data1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE: begin
        if (ccwait) w_next_state = C_LOOKUP;
      end
      C_LOOKUP: begin
        if (!ccwait)                        w_next_state = C_IDLE;
        else if (lk_hit && lk_dirty)        w_next_state = C_SUP1;
        else if (lk_hit && r_inv)           w_next_state = C_UPDATE;
        else                                w_next_state = C_DONE;
      end
      C_SUP1: begin
        if (!ccwait)     w_next_state = C_IDLE;
        else if (!dwait) w_next_state = C_SUP2;
      end
      C_SUP2: begin
        if (!ccwait)     w_next_state = C_IDLE;
        else if (!dwait) w_next_state = C_UPDATE;
      end
      // The array update is committed even if the controller drops ccwait.
      C_UPDATE: w_next_state = C_DONE;
      C_DONE: begin
        if (!ccwait) w_next_state = C_IDLE;
      end
      default: w_next_state = C_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cctrans    = 1'b0;
    ccwrite    = 1'b0;
    snp_dstore = 32'd0;
    upd_en     = 1'b0;
    upd_way    = 1'b0;
    upd_inv    = 1'b0;
    link_clr   = 1'b0;
    snoop_busy = (r_state != C_IDLE);
    case (r_state)
      C_LOOKUP: begin
        // Reservation is killed by any invalidating snoop to its block,
        // whether or not this cache holds the line.
        link_clr = r_inv && w_link_match;
      end
      C_SUP1: begin
        cctrans    = 1'b1;
        ccwrite    = 1'b1;
        snp_dstore = r_data0;
      end
      C_SUP2: begin
        cctrans    = 1'b1;
        ccwrite    = 1'b1;
        snp_dstore = r_data1;
      end
      C_UPDATE: begin
        cctrans = 1'b1;
        ccwrite = r_hit && r_dirty;
        upd_en  = 1'b1;
        upd_way = r_way;
        upd_inv = r_inv;
      end
      C_DONE: begin
        cctrans = 1'b1;
        ccwrite = r_hit && r_dirty;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoop_responder
// Description : Self-checking bench for snoop_responder. Each scenario task
//               queues per-cycle stimulus together with the expected outputs
//               for that cycle, then replays the queue and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ccwait;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic [31:0] lk_addr;
  logic        lk_hit;
  logic        lk_dirty;
  logic        lk_way;
  logic [31:0] lk_data0;
  logic [31:0] lk_data1;
  logic        dwait;
  logic        cctrans;
  logic        ccwrite;
  logic [31:0] snp_dstore;
  logic        upd_en;
  logic        upd_way;
  logic        upd_inv;
  logic [31:0] link_addr;
  logic        link_valid;
  logic        link_clr;
  logic        snoop_busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        ccw;
    logic        inv;
    logic        dw;
    logic        hit;
    logic        dirty;
    logic [31:0] addr;
  } stim_t;

  stim_t       stim_q[$];
  logic [70:0] exp_q[$];
  logic [70:0] obs;

  assign obs = {cctrans, ccwrite, upd_en, upd_way, upd_inv, link_clr, snoop_busy,
                snp_dstore, lk_addr};

  always #5 CLK = ~CLK;

  snoop_responder dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ccwait     (ccwait),
    .ccinv      (ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .lk_addr    (lk_addr),
    .lk_hit     (lk_hit),
    .lk_dirty   (lk_dirty),
    .lk_way     (lk_way),
    .lk_data0   (lk_data0),
    .lk_data1   (lk_data1),
    .dwait      (dwait),
    .cctrans    (cctrans),
    .ccwrite    (ccwrite),
    .snp_dstore (snp_dstore),
    .upd_en     (upd_en),
    .upd_way    (upd_way),
    .upd_inv    (upd_inv),
    .link_addr  (link_addr),
    .link_valid (link_valid),
    .link_clr   (link_clr),
    .snoop_busy (snoop_busy)
  );

  function automatic stim_t st(input logic ccw, input logic inv, input logic dw,
                               input logic hit, input logic dirty, input logic [31:0] addr);
    stim_t s;
    s.ccw = ccw; s.inv = inv; s.dw = dw; s.hit = hit; s.dirty = dirty; s.addr = addr;
    return s;
  endfunction

  // Expected output vector: cctrans, ccwrite, upd_en, upd_way, upd_inv,
  // link_clr, snoop_busy, snp_dstore, lk_addr.
  function automatic logic [70:0] ex(input logic cct, input logic ccw, input logic ue,
                                     input logic uw, input logic ui, input logic lc,
                                     input logic busy, input logic [31:0] ds,
                                     input logic [31:0] la);
    return {cct, ccw, ue, uw, ui, lc, busy, ds, la};
  endfunction

  task automatic sb_push(input stim_t s, input logic [70:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    ccwait = s.ccw; ccinv = s.inv; dwait = s.dw;
    lk_hit = s.hit; lk_dirty = s.dirty; ccsnoopaddr = s.addr;
  endtask

  task automatic test_reset;
    logic [70:0] e;
    nRST = 1'b0;
    ccwait = 1'b1; ccinv = 1'b0; ccsnoopaddr = 32'h0000_0F00; dwait = 1'b0;
    lk_hit = 1'b1; lk_dirty = 1'b1; lk_way = 1'b0;
    lk_data0 = 32'd0; lk_data1 = 32'd0; link_addr = 32'd0; link_valid = 1'b0;
    repeat (3) @(negedge CLK);
    e = ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", obs, e);
    end
    ccwait = 1'b0;
    #1 nRST = 1'b1;
    sb_push(st(0, 0, 0, 0, 0, 32'h0), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0));
    while (stim_q.size() > 0) begin
      @(posedge CLK); #1;
      apply(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_idle got=%h exp=%h", obs, e);
      end
    end
  endtask

  task automatic test_miss;
    logic [70:0] e;
    int cyc = 0;
    link_addr = 32'h0000_0100; link_valid = 1'b1;  // matching, but not invalidating
    sb_push(st(1, 0, 0, 0, 0, 32'h100), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h0));
    sb_push(st(1, 0, 0, 0, 0, 32'h100), ex(0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h100));
    sb_push(st(1, 0, 0, 1, 1, 32'h100), ex(1, 0, 0, 0, 0, 0, 1, 32'd0, 32'h100));
    sb_push(st(0, 0, 0, 1, 1, 32'h100), ex(1, 0, 0, 0, 0, 0, 1, 32'd0, 32'h100));
    sb_push(st(0, 0, 0, 0, 0, 32'h100), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h100));
    while (stim_q.size() > 0) begin
      @(posedge CLK); #1;
      apply(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL miss cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
    link_valid = 1'b0;
  endtask

  task automatic test_dirty_hit;
    logic [70:0] e;
    int cyc = 0;
    lk_way = 1'b1; lk_data0 = 32'hAAAA_0000; lk_data1 = 32'hBBBB_1111;
    sb_push(st(1, 0, 0, 1, 1, 32'h208), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h100));
    sb_push(st(1, 0, 0, 1, 1, 32'h208), ex(0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h208));
    sb_push(st(1, 0, 0, 0, 0, 32'h208), ex(1, 1, 0, 0, 0, 0, 1, 32'hAAAA_0000, 32'h208));
    sb_push(st(1, 0, 0, 0, 0, 32'h208), ex(1, 1, 0, 0, 0, 0, 1, 32'hBBBB_1111, 32'h208));
    sb_push(st(1, 0, 0, 0, 0, 32'h208), ex(1, 1, 1, 1, 0, 0, 1, 32'd0, 32'h208));
    sb_push(st(0, 0, 0, 0, 0, 32'h208), ex(1, 1, 0, 0, 0, 0, 1, 32'd0, 32'h208));
    sb_push(st(0, 0, 0, 0, 0, 32'h208), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h208));
    while (stim_q.size() > 0) begin
      @(posedge CLK); #1;
      apply(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL dirty_hit cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_dwait_stall;
    logic [70:0] e;
    int cyc = 0;
    lk_way = 1'b1; lk_data0 = 32'hAAAA_0000; lk_data1 = 32'hBBBB_1111;
    sb_push(st(1, 0, 0, 1, 1, 32'h208), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h208));
    sb_push(st(1, 0, 1, 1, 1, 32'h208), ex(0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h208));
    for (int i = 0; i < 3; i++)
      sb_push(st(1, 0, 1, 0, 0, 32'h208), ex(1, 1, 0, 0, 0, 0, 1, 32'hAAAA_0000, 32'h208));
    sb_push(st(1, 0, 0, 0, 0, 32'h208), ex(1, 1, 0, 0, 0, 0, 1, 32'hAAAA_0000, 32'h208));
    sb_push(st(1, 0, 0, 0, 0, 32'h208), ex(1, 1, 0, 0, 0, 0, 1, 32'hBBBB_1111, 32'h208));
    sb_push(st(1, 0, 0, 0, 0, 32'h208), ex(1, 1, 1, 1, 0, 0, 1, 32'd0, 32'h208));
    sb_push(st(0, 0, 0, 0, 0, 32'h208), ex(1, 1, 0, 0, 0, 0, 1, 32'd0, 32'h208));
    sb_push(st(0, 0, 0, 0, 0, 32'h208), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h208));
    while (stim_q.size() > 0) begin
      @(posedge CLK); #1;
      apply(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL dwait_stall cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_inv_link;
    logic [70:0] e;
    int cyc = 0;
    lk_way = 1'b0; lk_data0 = 32'h1234_5678; lk_data1 = 32'h9ABC_DEF0;
    link_addr = 32'h0000_0408; link_valid = 1'b1;
    // Clean hit, invalidating, same block as the reservation; ccwait is
    // dropped during UPDATE and the update must still complete.
    sb_push(st(1, 1, 0, 1, 0, 32'h40C), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h208));
    sb_push(st(1, 1, 0, 1, 0, 32'h40C), ex(0, 0, 0, 0, 0, 1, 1, 32'd0, 32'h40C));
    sb_push(st(0, 1, 0, 1, 0, 32'h40C), ex(1, 0, 1, 0, 1, 0, 1, 32'd0, 32'h40C));
    sb_push(st(0, 1, 0, 0, 0, 32'h40C), ex(1, 0, 0, 0, 0, 0, 1, 32'd0, 32'h40C));
    sb_push(st(0, 0, 0, 0, 0, 32'h40C), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h40C));
    // Invalidating miss to a different block: no reservation clear, no update.
    sb_push(st(1, 1, 0, 0, 0, 32'h418), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h40C));
    sb_push(st(1, 1, 0, 0, 0, 32'h418), ex(0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h418));
    sb_push(st(0, 1, 0, 0, 0, 32'h418), ex(1, 0, 0, 0, 0, 0, 1, 32'd0, 32'h418));
    sb_push(st(0, 0, 0, 0, 0, 32'h418), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h418));
    while (stim_q.size() > 0) begin
      @(posedge CLK); #1;
      apply(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL inv_link cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
    link_valid = 1'b0;
  endtask

  task automatic test_abort;
    logic [70:0] e;
    int cyc = 0;
    lk_way = 1'b1; lk_data0 = 32'hAAAA_0000; lk_data1 = 32'hBBBB_1111;
    sb_push(st(1, 0, 0, 1, 1, 32'h208), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h418));
    sb_push(st(1, 0, 0, 1, 1, 32'h208), ex(0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h208));
    sb_push(st(1, 0, 0, 0, 0, 32'h208), ex(1, 1, 0, 0, 0, 0, 1, 32'hAAAA_0000, 32'h208));
    sb_push(st(0, 0, 1, 0, 0, 32'h208), ex(1, 1, 0, 0, 0, 0, 1, 32'hBBBB_1111, 32'h208));
    sb_push(st(0, 0, 0, 0, 0, 32'h208), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h208));
    sb_push(st(0, 0, 0, 0, 0, 32'h208), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h208));
    while (stim_q.size() > 0) begin
      @(posedge CLK); #1;
      apply(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL abort cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_sup1;
    logic [70:0] e;
    int cyc = 0;
    lk_way = 1'b1; lk_data0 = 32'hAAAA_0000; lk_data1 = 32'hBBBB_1111;
    sb_push(st(1, 0, 1, 1, 1, 32'h210), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h208));
    sb_push(st(1, 0, 1, 1, 1, 32'h210), ex(0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h210));
    sb_push(st(1, 0, 1, 0, 0, 32'h210), ex(1, 1, 0, 0, 0, 0, 1, 32'hAAAA_0000, 32'h210));
    while (stim_q.size() > 0) begin
      @(posedge CLK); #1;
      apply(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rst_sup1 cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
    // Asynchronous reset between clock edges, ccwait still high.
    #1 nRST = 1'b0;
    #1;
    e = ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rst_async got=%h exp=%h", obs, e);
    end
    ccsnoopaddr = 32'h0000_0300; lk_hit = 1'b0; lk_dirty = 1'b0; dwait = 1'b0;
    #1 nRST = 1'b1;
    // The first edge after release accepts the pending snoop.
    sb_push(st(1, 0, 0, 0, 0, 32'h300), ex(0, 0, 0, 0, 0, 0, 1, 32'd0, 32'h300));
    sb_push(st(0, 0, 0, 0, 0, 32'h300), ex(1, 0, 0, 0, 0, 0, 1, 32'd0, 32'h300));
    sb_push(st(0, 0, 0, 0, 0, 32'h300), ex(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'h300));
    cyc = 0;
    while (stim_q.size() > 0) begin
      @(posedge CLK); #1;
      apply(stim_q.pop_front());
      @(negedge CLK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rst_release cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_miss();
    test_dirty_hit();
    test_dwait_stall();
    test_inv_link();
    test_abort();
    test_reset_mid_sup1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
